// File: rtl/alu_seq_param.sv
// Multi-cycle unsigned ALU: add, subtract (magnitude + sign), shift-add multiply,
// restoring divide. Add, subtract and divide-by-zero finish in one step. Multiply
// and divide take WIDTH iterations. The result is held until the next op completes.
//
// Handshake: start is a request that is accepted only on an edge where the FSM is
// IDLE and rst is low. Operands and opcode are captured on that edge. busy is high
// from the accepting edge until the FSM is back in IDLE. done is a one-cycle pulse
// that marks result/rem/neg/dz as valid. A start seen while busy is dropped; it is
// not queued.
module alu_seq_param #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           opcode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     rem,
  output logic                 neg,
  output logic                 dz,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic                 op_div;     // iterating op: 1 = divide, 0 = multiply
  logic [WIDTH-1:0]     b_q;        // latched divisor

  // Multiply datapath: accumulator, shifting multiplicand, shifting multiplier.
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mc;
  logic [WIDTH-1:0]     mp;

  // Divide datapath: partial remainder and the quotient/dividend shift register.
  logic [WIDTH-1:0]     pr;
  logic [WIDTH-1:0]     quo;

  logic [2*WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]     rem_q;
  logic                 neg_q;
  logic                 dz_q;

  // Single-cycle results computed straight from the input operands.
  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     sub_mag;
  logic                 sub_neg;

  // Next-iteration values for multiply and divide.
  logic [2*WIDTH-1:0]   mul_acc_nx;
  logic [2*WIDTH-1:0]   mul_mc_nx;
  logic [WIDTH-1:0]     mul_mp_nx;
  logic [WIDTH:0]       div_tmp;
  logic [WIDTH+1:0]     div_diff;
  logic [WIDTH-1:0]     div_pr_nx;
  logic [WIDTH-1:0]     div_quo_nx;

  logic                 last_iter;

  // Add/subtract results from the live operands.
  always_comb begin
    add_sum = {1'b0, a} + {1'b0, b};
    sub_neg = (a < b);
    sub_mag = sub_neg ? (b - a) : (a - b);
  end

  // One multiply step and one restoring-divide step.
  always_comb begin
    mul_acc_nx = mp[0] ? (acc + mc) : acc;
    mul_mc_nx  = mc << 1;
    mul_mp_nx  = mp >> 1;
    div_tmp    = {pr, quo[WIDTH-1]};
    div_diff   = {1'b0, div_tmp} - {2'b00, b_q};
    if (!div_diff[WIDTH+1]) begin
      // A non-negative trial is below the divisor, so it fits in WIDTH bits.
      div_pr_nx  = div_diff[WIDTH-1:0];
      div_quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      div_pr_nx  = div_tmp[WIDTH-1:0];
      div_quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Control FSM, operand capture, iteration registers and the held outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      b_q      <= '0;
      acc      <= '0;
      mc       <= '0;
      mp       <= '0;
      pr       <= '0;
      quo      <= '0;
      result_q <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_div <= opcode[0];
            b_q    <= b;
            cnt    <= '0;
            neg_q  <= 1'b0;
            dz_q   <= 1'b0;
            rem_q  <= '0;
            case (opcode)
              OP_ADD: begin
                result_q <= {{(WIDTH-1){1'b0}}, add_sum};
                state    <= S_DONE;
              end
              OP_SUB: begin
                result_q <= {{WIDTH{1'b0}}, sub_mag};
                neg_q    <= sub_neg;
                state    <= S_DONE;
              end
              OP_MUL: begin
                acc   <= '0;
                mc    <= {{WIDTH{1'b0}}, b};
                mp    <= a;
                state <= S_CALC;
              end
              default: begin
                if (b == '0) begin
                  // Divide by zero skips the iterations entirely.
                  dz_q     <= 1'b1;
                  result_q <= '1;
                  rem_q    <= a;
                  state    <= S_DONE;
                end else begin
                  pr    <= '0;
                  quo   <= a;
                  state <= S_CALC;
                end
              end
            endcase
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (op_div) begin
            pr  <= div_pr_nx;
            quo <= div_quo_nx;
          end else begin
            acc <= mul_acc_nx;
            mc  <= mul_mc_nx;
            mp  <= mul_mp_nx;
          end
          if (last_iter) begin
            // The final step's values go straight to the outputs on the DONE edge.
            state <= S_DONE;
            cnt   <= '0;
            if (op_div) begin
              result_q <= {{WIDTH{1'b0}}, div_quo_nx};
              rem_q    <= div_pr_nx;
            end else begin
              result_q <= mul_acc_nx;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign rem    = rem_q;
  assign neg    = neg_q;
  assign dz     = dz_q;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

endmodule
